// File: rtl/serial_rx_ctrl.sv
// Receive sequencer for an idle-high serial line: finds the start bit, drives an external
// 10-bit SIPO (shift clock, data, clear), checks the stop bit and hands the byte over valid/ready.
module serial_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_in,
    output logic              sr_clk,
    output logic              sr_reset,
    output logic              sr_data,
    input  logic [DATA_W-1:0] sr_par_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              framing_err,
    output logic              overrun_err
);

    localparam int SW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 2);
    localparam logic [SW-1:0] HALF_M1   = SW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [SW-1:0] FULL_M1   = SW'(CLKS_PER_BIT - 1);
    localparam logic [SW-1:0] SETTLE    = SW'(2);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CHECK, BRK} state_t;

    state_t          state, state_nxt;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic [SW-1:0]   samp_cnt;
    logic [BW-1:0]   bit_cnt;
    logic            stop_bit;
    logic            shift_pend;
    logic            sample, samp_clr, done;
    logic            capture, overrun, framing;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!rx_s) state_nxt = START;
            START: if (samp_cnt == HALF_M1) state_nxt = rx_s ? IDLE : DATA;
            DATA:  if (samp_cnt == FULL_M1 && bit_cnt == LAST_DATA) state_nxt = STOP;
            STOP:  if (samp_cnt == FULL_M1) state_nxt = CHECK;
            CHECK: if (samp_cnt == SETTLE) state_nxt = stop_bit ? IDLE : BRK;
            BRK:   if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sample   = 1'b0;
        samp_clr = 1'b0;
        done     = 1'b0;
        case (state)
            START: if (samp_cnt == HALF_M1) begin
                samp_clr = 1'b1;
                sample   = !rx_s;
            end
            DATA, STOP: if (samp_cnt == FULL_M1) begin
                samp_clr = 1'b1;
                sample   = 1'b1;
            end
            CHECK: done = (samp_cnt == SETTLE);
            default: ;
        endcase
        // A same-cycle accept frees the holding register, so the new byte is not an overrun.
        capture = done && stop_bit && (!rx_valid || rx_ready);
        overrun = done && stop_bit && rx_valid && !rx_ready;
        framing = done && !stop_bit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q      <= 2'b11;
            samp_cnt    <= '0;
            bit_cnt     <= '0;
            stop_bit    <= 1'b1;
            shift_pend  <= 1'b0;
            sr_clk      <= 1'b0;
            sr_reset    <= 1'b1;
            sr_data     <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx_in};

            if (state == IDLE || state == BRK || samp_clr) samp_cnt <= '0;
            else                                           samp_cnt <= samp_cnt + SW'(1);

            if (state == IDLE)                         bit_cnt <= '0;
            else if (sample && state == START)         bit_cnt <= BW'(1);
            else if (sample && state == DATA)          bit_cnt <= bit_cnt + BW'(1);

            if (sample && state == STOP) stop_bit <= rx_s;
            if (sample)                  sr_data  <= rx_s;

            // sr_data leads the shift clock by one cycle and holds past its fall.
            shift_pend <= sample;
            sr_clk     <= shift_pend;
            sr_reset   <= (state_nxt == IDLE);

            if (capture) begin
                rx_data  <= sr_par_in;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            framing_err <= framing;
            overrun_err <= overrun;
        end
    end

endmodule
